fetch_unit: RTL and testbench

//  - Instruction-fetch stage of the RV32I core. Holds the PC and drives the byte address into IMEM.
//  - Registers the returned instruction with its PC and hands it to decode over a valid/ready handshake.
//  - Handles branch/jump redirects.
//  - Traps on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the RV32I core.
//
// Holds the PC and drives it as a byte address into IMEM. The word that IMEM
// returns is registered together with its PC and offered to decode over a
// valid/ready handshake. Taken branches and jumps redirect the PC and flush
// the held instruction. A misaligned redirect target, or a fetch from a word
// index at or beyond MEM_DEPTH_WORDS, traps into a sticky FAULT state that
// only rst_n clears.
//
// Optional feature: define FETCH_PERF_EN to build the two 32-bit performance
// counters. Without it, both perf outputs are tied to zero.
//
// Parameters
//   RESET_PC         PC loaded on reset
//   MEM_DEPTH_WORDS  IMEM depth in 32-bit words
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   imem_addr        byte address to IMEM (the PC register)
//   imem_instr       instruction word read combinationally at imem_addr
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      redirect target byte address
//   if_valid         if_pc/if_instr hold a fetched instruction
//   if_ready         decode accepts if_* this cycle
//   if_pc, if_instr  PC and word of the held instruction
//   if_pc_plus4      if_pc + 4, combinational
//   fault            sticky fetch fault
//   fault_cause      0 none, 1 misaligned redirect, 2 out-of-range fetch
//   fault_pc         offending address
//   perf_fetch_cnt   instructions transferred to decode
//   perf_stall_cnt   cycles with if_valid && !if_ready
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned MEM_DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc_plus4,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_pc,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [31:0] DEPTH_WORDS    = 32'(MEM_DEPTH_WORDS);
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
   localparam logic [1:0]  CAUSE_NONE     = 2'd0;
   localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0]  CAUSE_RANGE    = 2'd2;

   state_t      state_r, state_n;
   logic [31:0] pc_r, pc_n;
   logic        if_valid_r, if_valid_n;
   logic [31:0] if_pc_r, if_pc_n;
   logic [31:0] if_instr_r, if_instr_n;
   logic        fault_r, fault_n;
   logic [1:0]  cause_r, cause_n;
   logic [31:0] fault_pc_r, fault_pc_n;
   logic        fire_s;
   logic        in_range_s;

   // The output register can take a new word when it is empty or being drained.
   assign fire_s     = !if_valid_r || if_ready;
   // Range is judged on the word index, so the two low PC bits never matter.
   assign in_range_s = ({2'b00, pc_r[31:2]} < DEPTH_WORDS);

   // Next-state and next-value logic; redirect outranks fetch, fetch outranks stall.
   always_comb begin
      state_n    = state_r;
      pc_n       = pc_r;
      if_valid_n = if_valid_r;
      if_pc_n    = if_pc_r;
      if_instr_n = if_instr_r;
      fault_n    = fault_r;
      cause_n    = cause_r;
      fault_pc_n = fault_pc_r;
      case (state_r)
         ST_IDLE: begin
            state_n = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               // Flush regardless of if_ready: the held instruction is on the wrong path.
               if_valid_n = 1'b0;
               if (redirect_pc[1:0] == 2'b00) begin
                  pc_n = redirect_pc;
               end else begin
                  state_n    = ST_FAULT;
                  fault_n    = 1'b1;
                  cause_n    = CAUSE_MISALIGN;
                  fault_pc_n = redirect_pc;
               end
            end else if (fire_s) begin
               if (in_range_s) begin
                  if_valid_n = 1'b1;
                  if_pc_n    = pc_r;
                  if_instr_n = imem_instr;
                  pc_n       = pc_r + 32'd4;
               end else begin
                  state_n    = ST_FAULT;
                  if_valid_n = 1'b0;
                  fault_n    = 1'b1;
                  cause_n    = CAUSE_RANGE;
                  fault_pc_n = pc_r;
               end
            end else begin
               // Stall: everything offered to decode holds.
               if_valid_n = if_valid_r;
            end
         end
         ST_FAULT: begin
            if_valid_n = 1'b0;
         end
         default: begin
            state_n    = ST_IDLE;
            if_valid_n = 1'b0;
         end
      endcase
   end

   // State, PC, output register and fault record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         pc_r       <= RESET_PC;
         if_valid_r <= 1'b0;
         if_pc_r    <= 32'h0000_0000;
         if_instr_r <= NOP_INSTR;
         fault_r    <= 1'b0;
         cause_r    <= CAUSE_NONE;
         fault_pc_r <= 32'h0000_0000;
      end else begin
         state_r    <= state_n;
         pc_r       <= pc_n;
         if_valid_r <= if_valid_n;
         if_pc_r    <= if_pc_n;
         if_instr_r <= if_instr_n;
         fault_r    <= fault_n;
         cause_r    <= cause_n;
         fault_pc_r <= fault_pc_n;
      end
   end

   assign imem_addr   = pc_r;
   assign if_valid    = if_valid_r;
   assign if_pc       = if_pc_r;
   assign if_instr    = if_instr_r;
   assign if_pc_plus4 = if_pc_r + 32'd4;
   assign fault       = fault_r;
   assign fault_cause = cause_r;
   assign fault_pc    = fault_pc_r;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] stall_cnt_r;
   logic        transfer_s;
   logic        stall_s;

   assign transfer_s = if_valid_r && if_ready;
   assign stall_s    = if_valid_r && !if_ready;

   // Free-running wrap-around counters of transfers and backpressure cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_r <= 32'h0000_0000;
         stall_cnt_r <= 32'h0000_0000;
      end else begin
         if (transfer_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
         end else begin
            fetch_cnt_r <= fetch_cnt_r;
         end
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign perf_fetch_cnt = fetch_cnt_r;
   assign perf_stall_cnt = stall_cnt_r;
`else
   assign perf_fetch_cnt = 32'h0000_0000;
   assign perf_stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Two instances share clock and reset: a full-size one (1024 words) that takes
// directed and random redirect/backpressure stimulus, and a 16-word one that
// runs straight-line code into the out-of-range trap. Both are compared every
// cycle with a transaction-level model of the fetch rules.
module tb_fetch_unit;

   typedef struct {
      logic        started;
      logic        faulted;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] iinstr;
      logic [1:0]  cause;
      logic [31:0] fpc;
      logic [31:0] nfetch;
      logic [31:0] nstall;
   } mstate_t;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_ready;

   logic [31:0] imem_addr, imem_instr, if_pc, if_instr, if_pc_plus4, fault_pc;
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
   logic        if_valid, fault;
   logic [1:0]  fault_cause;

   logic [31:0] s_imem_addr, s_imem_instr, s_if_pc, s_if_instr, s_if_pc_plus4, s_fault_pc;
   logic [31:0] s_perf_fetch_cnt, s_perf_stall_cnt;
   logic        s_if_valid, s_fault;
   logic [1:0]  s_fault_cause;
   logic        s_redirect_valid;
   logic [31:0] s_redirect_pc;
   logic        s_if_ready;

   int          errors = 0;
   int          checks = 0;
   mstate_t     m;
   mstate_t     ms;

   // IMEM word k holds the value k.
   assign imem_instr       = {2'b00, imem_addr[31:2]};
   assign s_imem_instr     = {2'b00, s_imem_addr[31:2]};
   assign s_redirect_valid = 1'b0;
   assign s_redirect_pc    = 32'h0000_0000;
   assign s_if_ready       = 1'b1;

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_DEPTH_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
      .if_pc_plus4(if_pc_plus4), .fault(fault), .fault_cause(fault_cause),
      .fault_pc(fault_pc), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt));

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_DEPTH_WORDS(16)) dut_small (
      .clk(clk), .rst_n(rst_n), .imem_addr(s_imem_addr), .imem_instr(s_imem_instr),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .if_valid(s_if_valid), .if_ready(s_if_ready), .if_pc(s_if_pc), .if_instr(s_if_instr),
      .if_pc_plus4(s_if_pc_plus4), .fault(s_fault), .fault_cause(s_fault_cause),
      .fault_pc(s_fault_pc), .perf_fetch_cnt(s_perf_fetch_cnt), .perf_stall_cnt(s_perf_stall_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mstate_t model_reset();
      mstate_t s;
      s.started = 1'b0;
      s.faulted = 1'b0;
      s.valid   = 1'b0;
      s.pc      = 32'h0000_0000;
      s.ipc     = 32'h0000_0000;
      s.iinstr  = 32'h0000_0013;
      s.cause   = 2'd0;
      s.fpc     = 32'h0000_0000;
      s.nfetch  = 32'h0000_0000;
      s.nstall  = 32'h0000_0000;
      return s;
   endfunction

   // One clock edge of the fetch stage, applied to the rules in priority order.
   function automatic mstate_t model_step(input mstate_t s, input logic rv, input logic [31:0] rpc,
                                          input logic rdy, input int unsigned depth);
      mstate_t n = s;
      if (s.valid && rdy)  n.nfetch = s.nfetch + 32'd1;
      if (s.valid && !rdy) n.nstall = s.nstall + 32'd1;
      if (!s.started) begin
         n.started = 1'b1;
      end else if (!s.faulted) begin
         if (rv) begin
            n.valid = 1'b0;
            if (rpc % 32'd4 == 32'd0) begin
               n.pc = rpc;
            end else begin
               n.faulted = 1'b1; n.cause = 2'd1; n.fpc = rpc;
            end
         end else if (!s.valid || rdy) begin
            if ((s.pc / 32'd4) < depth) begin
               n.valid  = 1'b1;
               n.ipc    = s.pc;
               n.iinstr = s.pc / 32'd4;
               n.pc     = s.pc + 32'd4;
            end else begin
               n.valid = 1'b0; n.faulted = 1'b1; n.cause = 2'd2; n.fpc = s.pc;
            end
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string p, input mstate_t e,
                            input logic [31:0] a, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] pc4, input logic f,
                            input logic [1:0] fc, input logic [31:0] fpc,
                            input logic [31:0] pf, input logic [31:0] ps);
      logic [31:0] exp_pf;
      logic [31:0] exp_ps;
`ifdef FETCH_PERF_EN
      exp_pf = e.nfetch;
      exp_ps = e.nstall;
`else
      exp_pf = 32'h0000_0000;
      exp_ps = 32'h0000_0000;
`endif
      chk({p, "imem_addr"},   a,         e.pc);
      chk({p, "if_valid"},    32'(v),    32'(e.valid));
      chk({p, "if_pc"},       pc,        e.ipc);
      chk({p, "if_instr"},    ins,       e.iinstr);
      chk({p, "if_pc_plus4"}, pc4,       e.ipc + 32'd4);
      chk({p, "fault"},       32'(f),    32'(e.faulted));
      chk({p, "fault_cause"}, 32'(fc),   32'(e.cause));
      chk({p, "fault_pc"},    fpc,       e.fpc);
      chk({p, "perf_fetch"},  pf,        exp_pf);
      chk({p, "perf_stall"},  ps,        exp_ps);
   endtask

   task automatic check_all();
      check_dut("main.", m, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4, fault,
                fault_cause, fault_pc, perf_fetch_cnt, perf_stall_cnt);
      check_dut("small.", ms, s_imem_addr, s_if_valid, s_if_pc, s_if_instr, s_if_pc_plus4,
                s_fault, s_fault_cause, s_fault_pc, s_perf_fetch_cnt, s_perf_stall_cnt);
   endtask

   // Called at a falling edge with inputs already driven; advances one cycle.
   task automatic tick();
      @(posedge clk);
      m  = model_step(m, redirect_valid, redirect_pc, if_ready, 1024);
      ms = model_step(ms, 1'b0, 32'h0000_0000, 1'b1, 16);
      @(negedge clk);
      check_all();
   endtask

   // Asserts rst_n between clock edges, checks the immediate effect, releases at the next fall.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      m  = model_reset();
      ms = model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      m              = model_reset();
      ms             = model_reset();
      @(negedge clk);
      do_reset();

      // Reset release, first fetches, and the small instance running off the end.
      tick();
      chk("t1_idle_valid", 32'(if_valid), 32'h0);
      tick();
      chk("t1_pc0", if_pc, 32'h0);   chk("t1_instr0", if_instr, 32'h0);
      tick();
      chk("t1_pc1", if_pc, 32'h4);   chk("t1_instr1", if_instr, 32'h1);
      tick();
      chk("t1_pc2", if_pc, 32'h8);   chk("t1_instr2", if_instr, 32'h2);
      repeat (13) tick();
      chk("t5_last_valid", 32'(s_if_valid), 32'h1);
      chk("t5_last_pc", s_if_pc, 32'h3C);
      tick();
      chk("t5_fault", 32'(s_fault), 32'h1);
      chk("t5_cause", 32'(s_fault_cause), 32'h2);
      chk("t5_fault_pc", s_fault_pc, 32'h40);
      chk("t5_valid", 32'(s_if_valid), 32'h0);

      // Backpressure while if_pc = 0x8.
      do_reset();
      repeat (4) tick();
      if_ready = 1'b0;
      repeat (3) begin
         tick();
         chk("t2_hold_pc", if_pc, 32'h8);
         chk("t2_hold_addr", imem_addr, 32'hC);
      end
      if_ready = 1'b1;
      tick();
      chk("t2_release_pc", if_pc, 32'hC);

      // Redirect while stalled.
      if_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      chk("t3_flush", 32'(if_valid), 32'h0);
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      tick();
      chk("t3_target_pc", if_pc, 32'h40);
      chk("t3_plus4", if_pc_plus4, 32'h44);

      // Random backpressure with in-range aligned redirects.
      repeat (200) begin
         if_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
         tick();
      end
      redirect_valid = 1'b0;

      // Misaligned redirect and the ignored redirect that follows.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      tick();
      chk("t4_fault", 32'(fault), 32'h1);
      chk("t4_cause", 32'(fault_cause), 32'h1);
      chk("t4_fault_pc", fault_pc, 32'h42);
      chk("t4_valid", 32'(if_valid), 32'h0);
      redirect_pc = 32'h0;
      tick();
      chk("t4_ignored_fpc", fault_pc, 32'h42);
      chk("t4_ignored_valid", 32'(if_valid), 32'h0);
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      repeat (3) tick();

      // Performance counters: 5 transfers then 3 stall cycles, then a mid-run reset.
      do_reset();
      if_ready = 1'b1;
      repeat (2) tick();
      repeat (5) tick();
      if_ready = 1'b0;
      repeat (3) tick();
`ifdef FETCH_PERF_EN
      chk("t6_fetch_cnt", perf_fetch_cnt, 32'd5);
      chk("t6_stall_cnt", perf_stall_cnt, 32'd3);
`else
      chk("t6_fetch_cnt", perf_fetch_cnt, 32'd0);
      chk("t6_stall_cnt", perf_stall_cnt, 32'd0);
`endif
      do_reset();

      // Aligned redirect beyond IMEM faults only on the following fetch.
      if_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1000;
      tick();
      chk("t7_no_fault_yet", 32'(fault), 32'h0);
      redirect_valid = 1'b0;
      tick();
      chk("t7_fault", 32'(fault), 32'h1);
      chk("t7_cause", 32'(fault_cause), 32'h2);
      chk("t7_fault_pc", fault_pc, 32'h0000_1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
